diff_scan_ctrl: RTL and testbench



---
 rtl/diff_scan_ctrl_pkg.sv | 16 +
 rtl/diff_scan_ctrl_lsb_index_enc.sv | 28 ++
 rtl/diff_scan_ctrl.sv | 101 ++++++++++
 tb/tb_diff_scan_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/diff_scan_ctrl_pkg.sv
// Shared definitions for the diff-scan controller: default widths and FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package diff_scan_ctrl_pkg;

  localparam int DSC_WIDTH = 32;  // operand width, power of two
  localparam int DSC_IDX_W = 5;   // log2(WIDTH)
  localparam int DSC_CNT_W = 6;   // log2(WIDTH)+1, count must reach WIDTH

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/diff_scan_ctrl_lsb_index_enc.sv
// Lowest-set-bit encoder: isolates the lowest set bit, then one-hot to binary encodes it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: x_i word to scan; idx_o index of lowest set bit (0 when x_i == 0); zero_o x_i == 0.
module lsb_index_enc #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] iso;

  // x ^ (x-1) sets every bit up to and including the lowest set bit; masking
  // with x leaves only that bit. For x == 0 the result is 0, so idx_o is 0.
  assign iso    = x_i & (x_i ^ (x_i - WIDTH'(1)));
  assign zero_o = (x_i == '0);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (iso[i]) idx_o = idx_o | IDX_W'(i);
    end
  end

endmodule

// File: rtl/diff_scan_ctrl.sv
// Diff-scan controller: latches a ^ b on start and emits the index of every differing bit, lowest first.
// Latency: first index the cycle after start, one per cycle with ready high; done 2 cycles after last handshake.
// Backpressure: idx_valid_o/idx_o hold stable while idx_ready_i is low; abort_i cancels the scan.
// Ports: start_i/abort_i control; operand_a_i/operand_b_i operands; idx_valid_o/idx_ready_i/idx_o index stream;
//        busy_o scan active; done_o completion pulse; equal_o operands identical; count_o indices accepted.
module diff_scan_ctrl
  import diff_scan_ctrl_pkg::*;
#(
  parameter int WIDTH = DSC_WIDTH,
  parameter int IDX_W = DSC_IDX_W,
  parameter int CNT_W = DSC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             equal_o,
  output logic [CNT_W-1:0] count_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             equal_q, equal_d;
  logic             work_zero;
  logic             hs;

  lsb_index_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .x_i    (work_q),
    .idx_o  (idx_o),
    .zero_o (work_zero)
  );

  // work_q is only nonzero in SCAN (cleared on abort, drained before DONE),
  // so idx_o reads 0 whenever idx_valid_o is low.
  assign idx_valid_o = (state_q == ST_SCAN) && !work_zero;
  assign hs          = idx_valid_o && idx_ready_i;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign equal_o     = equal_q;
  assign count_o     = count_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    equal_d = equal_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          work_d  = operand_a_i ^ operand_b_i;
          count_d = '0;
          equal_d = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // hs implies work_q != 0, so work_q - 1 never wraps.
        if (hs) begin
          work_d  = work_q & (work_q - WIDTH'(1));
          count_d = count_q + CNT_W'(1);
        end
        if (abort_i) begin
          work_d  = '0;
          equal_d = 1'b0;
          state_d = ST_IDLE;
        end else if (work_zero) begin
          equal_d = (count_q == '0);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      count_q <= '0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      equal_q <= equal_d;
    end
  end

endmodule

// File: tb/tb_diff_scan_ctrl.sv
// Directed bench for diff_scan_ctrl with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
// All comparisons go through chk().
module tb_diff_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        idx_valid_o;
  logic        idx_ready_i = 1'b0;
  logic [4:0]  idx_o;
  logic        busy_o;
  logic        done_o;
  logic        equal_o;
  logic [5:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  diff_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .idx_valid_o (idx_valid_o),
    .idx_ready_i (idx_ready_i),
    .idx_o       (idx_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .equal_o     (equal_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " valid"}, 32'(idx_valid_o), 32'd0);
    chk({tag, " idx"},   32'(idx_o),       32'd0);
    chk({tag, " busy"},  32'(busy_o),      32'd0);
    chk({tag, " done"},  32'(done_o),      32'd0);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    operand_a_i = a;
    operand_b_i = b;
    start_i     = 1'b1;
    step();
    start_i     = 1'b0;
  endtask

  initial begin
    int cyc;
    // ---- reset state
    #2;
    chk_idle_outputs("rst");
    chk("rst equal", 32'(equal_o), 32'd0);
    chk("rst count", 32'(count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- T1: 0x12 -> indices 1, 4; done at cycle 4
    idx_ready_i = 1'b1;
    launch(32'h0000_0012, 32'h0);
    chk("t1 c1 valid", 32'(idx_valid_o), 32'd1);
    chk("t1 c1 idx",   32'(idx_o),       32'd1);
    step();
    chk("t1 c2 valid", 32'(idx_valid_o), 32'd1);
    chk("t1 c2 idx",   32'(idx_o),       32'd4);
    step();
    chk("t1 c3 valid", 32'(idx_valid_o), 32'd0);
    chk("t1 c3 busy",  32'(busy_o),      32'd1);
    chk("t1 c3 done",  32'(done_o),      32'd0);
    step();
    chk("t1 c4 done",  32'(done_o),      32'd1);
    chk("t1 count",    32'(count_o),     32'd2);
    chk("t1 equal",    32'(equal_o),     32'd0);
    step();
    chk("t1 c5 done",  32'(done_o),      32'd0);
    chk("t1 c5 busy",  32'(busy_o),      32'd0);

    // ---- T2: identical operands -> done at cycle 2, equal
    launch(32'hDEAD_BEEF, 32'hDEAD_BEEF);
    chk("t2 c1 valid", 32'(idx_valid_o), 32'd0);
    chk("t2 c1 busy",  32'(busy_o),      32'd1);
    step();
    chk("t2 c2 valid", 32'(idx_valid_o), 32'd0);
    chk("t2 c2 done",  32'(done_o),      32'd1);
    chk("t2 equal",    32'(equal_o),     32'd1);
    chk("t2 count",    32'(count_o),     32'd0);
    step();

    // ---- T3: 0x80000001 with ready low for 3 cycles
    idx_ready_i = 1'b0;
    launch(32'h8000_0001, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("t3 hold%0d valid", i), 32'(idx_valid_o), 32'd1);
      chk($sformatf("t3 hold%0d idx", i),   32'(idx_o),       32'd0);
      if (i < 3) step();
    end
    idx_ready_i = 1'b1;
    step();
    chk("t3 second valid", 32'(idx_valid_o), 32'd1);
    chk("t3 second idx",   32'(idx_o),       32'd31);
    cyc = 0;
    while (!done_o && cyc < 10) begin
      step();
      cyc++;
    end
    chk("t3 done seen", 32'(done_o), 32'd1);
    chk("t3 done delay", 32'(cyc), 32'd2);
    chk("t3 count", 32'(count_o), 32'd2);
    chk("t3 equal", 32'(equal_o), 32'd0);
    step();

    // ---- T4: all 32 bits differ -> 0..31 back to back
    launch(32'hFFFF_FFFF, 32'h0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t4 idx%0d", i), {idx_valid_o, 26'd0, idx_o}, {1'b1, 26'd0, 5'(i)});
      chk($sformatf("t4 nodone%0d", i), 32'(done_o), 32'd0);
      step();
    end
    chk("t4 drained valid", 32'(idx_valid_o), 32'd0);
    chk("t4 drained done",  32'(done_o),      32'd0);
    step();
    chk("t4 done",  32'(done_o),  32'd1);
    chk("t4 count", 32'(count_o), 32'd32);
    step();
    chk("t4 done once", 32'(done_o), 32'd0);

    // ---- T5: 0xF0, abort the cycle after the first handshake; start during SCAN ignored
    launch(32'h0000_00F0, 32'h0);
    chk("t5 c1 idx", 32'(idx_o), 32'd4);
    step();
    chk("t5 c2 idx", 32'(idx_o), 32'd5);
    idx_ready_i = 1'b0;
    abort_i     = 1'b1;
    start_i     = 1'b1;
    operand_a_i = 32'h0000_0001;
    step();
    abort_i = 1'b0;
    start_i = 1'b0;
    chk_idle_outputs("t5 abort");
    chk("t5 count", 32'(count_o), 32'd1);
    chk("t5 equal", 32'(equal_o), 32'd0);
    step();
    chk("t5 no queued start", 32'(busy_o), 32'd0);
    chk("t5 no late done",    32'(done_o), 32'd0);

    // ---- T5b: abort with a handshake in the same cycle still counts
    idx_ready_i = 1'b1;
    launch(32'h0000_0003, 32'h0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk_idle_outputs("t5b abort");
    chk("t5b count", 32'(count_o), 32'd1);

    // ---- T6: asynchronous reset mid-scan
    launch(32'h0000_0F0F, 32'h0);
    step();
    chk("t6 busy before rst", 32'(busy_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6 in rst");
    chk("t6 count", 32'(count_o), 32'd0);
    chk("t6 equal", 32'(equal_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle_outputs("t6 after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
